// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: display fetch port, CPU access port and the single RAM port.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface vram_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  dispReq;
    logic [ADDR_WIDTH-1:0] dispAddr;
    logic                  dispValid;
    logic [7:0]            dispData;
    logic                  dispMiss;

    logic                  cpuReq;
    logic                  cpuWrite;
    logic [ADDR_WIDTH-1:0] cpuAddr;
    logic [7:0]            cpuDataIn;
    logic                  cpuAck;
    logic [7:0]            cpuDataOut;

    logic                  ramWriteEnabled;
    logic [ADDR_WIDTH-1:0] ramAddress;
    logic [7:0]            ramDataIn;
    logic [7:0]            ramDataOut;

    modport slave (
        input  dispReq, dispAddr, cpuReq, cpuWrite, cpuAddr, cpuDataIn, ramDataOut,
        output dispValid, dispData, dispMiss, cpuAck, cpuDataOut,
               ramWriteEnabled, ramAddress, ramDataIn
    );

    modport master (
        output dispReq, dispAddr, cpuReq, cpuWrite, cpuAddr, cpuDataIn, ramDataOut,
        input  dispValid, dispData, dispMiss, cpuAck, cpuDataOut,
               ramWriteEnabled, ramAddress, ramDataIn
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches win by default, a waiting CPU access wins when
// the display is idle or after MAX_WAIT refusals. RAM read data returns one cycle after grant.
module vram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 8
) (
    input logic           clk,
    input logic           reset,
    vram_arbiter_if.slave bus
);
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_ISSUE, C_ACK} cpuState_t;

    cpuState_t             state;
    cpuState_t             stateNext;
    logic [CNT_W-1:0]      waitCnt;
    logic                  cpuGrant;
    logic                  dispGrant;
    logic                  dispInFlight;
    logic                  readInFlight;
    logic                  ackNow;
    logic [ADDR_WIDTH-1:0] lastAddr;
    logic [7:0]            dispHold;
    logic [7:0]            cpuHold;

    // NOTE: every signal gets a default before the case so this block never infers a latch.
    always_comb begin
        stateNext = state;
        cpuGrant  = 1'b0;
        unique case (state)
            C_IDLE:  if (bus.cpuReq) stateNext = C_WAIT;
            C_WAIT:  if (!bus.dispReq || waitCnt == WAIT_LIMIT) begin
                         cpuGrant  = 1'b1;
                         stateNext = C_ISSUE;
                     end
            C_ISSUE: stateNext = C_ACK;
            C_ACK:   stateNext = C_IDLE;
            default: stateNext = C_IDLE;
        endcase
        // Reset suppresses grants so nothing reaches the RAM during the reset cycle.
        if (reset) cpuGrant = 1'b0;
        dispGrant = bus.dispReq && !cpuGrant && !reset;
    end

    always_comb begin
        ackNow              = (state == C_ISSUE) && !reset;
        bus.ramWriteEnabled = cpuGrant && bus.cpuWrite;
        bus.ramAddress      = lastAddr;
        bus.ramDataIn       = '0;
        if (cpuGrant) begin
            bus.ramAddress = bus.cpuAddr;
            if (bus.cpuWrite) bus.ramDataIn = bus.cpuDataIn;
        end else if (dispGrant) begin
            bus.ramAddress = bus.dispAddr;
        end
        bus.dispMiss   = bus.dispReq && cpuGrant;
        bus.dispValid  = dispInFlight && !reset;
        bus.dispData   = bus.dispValid ? bus.ramDataOut : dispHold;
        bus.cpuAck     = ackNow;
        bus.cpuDataOut = (ackNow && readInFlight) ? bus.ramDataOut : cpuHold;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= C_IDLE;
            waitCnt      <= '0;
            dispInFlight <= 1'b0;
            readInFlight <= 1'b0;
            lastAddr     <= '0;
            dispHold     <= '0;
            cpuHold      <= '0;
        end else begin
            state <= stateNext;
            if (cpuGrant)
                waitCnt <= '0;
            else if (state == C_WAIT && bus.dispReq && waitCnt != WAIT_LIMIT)
                waitCnt <= waitCnt + 1'b1;
            dispInFlight <= dispGrant;
            if (cpuGrant) readInFlight <= !bus.cpuWrite;
            lastAddr <= bus.ramAddress;
            dispHold <= bus.dispData;
            cpuHold  <= bus.cpuDataOut;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a cycle-count/event model of the arbiter.
module tb_vram_arbiter;
    localparam int ADDR_WIDTH = 16;
    localparam int MAX_WAIT   = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    vram_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read RAM: data for the address presented in cycle N appears in cycle N+1.
    logic [7:0] ramMem [65536] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.ramWriteEnabled) ramMem[bus.ramAddress] <= bus.ramDataIn;
        bus.ramDataOut <= ramMem[bus.ramAddress];
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: tracks a pending CPU request by the cycle it became eligible, counts
    // refusals, and schedules acks/display data by absolute cycle number.
    logic [7:0]            shadow [65536] = '{default: 8'h00};
    bit                    modelLive   = 0;
    bit                    mPending    = 0;
    int                    mEligible   = 0;
    int                    mAcceptFrom = 0;
    int                    mRefused    = 0;
    int                    mAckCycle   = -1;
    bit                    mAckRead    = 0;
    logic [7:0]            mAckData    = '0;
    bit                    mDispDue    = 0;
    logic [7:0]            mDispDueData = '0;
    logic [7:0]            mDispHold   = '0;
    logic [7:0]            mCpuHold    = '0;
    logic [ADDR_WIDTH-1:0] mLastAddr   = '0;

    task automatic modelCompare();
        bit                    cpuWin;
        bit                    dispWin;
        bit                    expWe;
        bit                    expAck;
        logic [ADDR_WIDTH-1:0] expAddr;
        logic [7:0]            expCpuOut;
        logic [7:0]            expDispData;
        if (reset) begin
            modelLive   = 1;
            mPending    = 0;
            mRefused    = 0;
            mAckCycle   = -1;
            mAcceptFrom = cyc + 1;
            mDispDue    = 0;
            mDispHold   = '0;
            mCpuHold    = '0;
            mLastAddr   = '0;
        end else if (modelLive) begin
            cpuWin      = mPending && cyc >= mEligible && (!bus.dispReq || mRefused == MAX_WAIT);
            dispWin     = bus.dispReq && !cpuWin;
            expWe       = cpuWin && bus.cpuWrite;
            expAddr     = cpuWin ? bus.cpuAddr : (dispWin ? bus.dispAddr : mLastAddr);
            expAck      = (cyc == mAckCycle);
            expCpuOut   = (expAck && mAckRead) ? mAckData : mCpuHold;
            expDispData = mDispDue ? mDispDueData : mDispHold;

            check("dispValid", bus.dispValid, mDispDue);
            check("dispData", bus.dispData, expDispData);
            check("dispMiss", bus.dispMiss, bus.dispReq && cpuWin);
            check("cpuAck", bus.cpuAck, expAck);
            check("cpuDataOut", bus.cpuDataOut, expCpuOut);
            check("ramWriteEnabled", bus.ramWriteEnabled, expWe);
            check("ramAddress", bus.ramAddress, expAddr);
            if (expWe) check("ramDataIn", bus.ramDataIn, bus.cpuDataIn);

            mCpuHold  = expCpuOut;
            mDispHold = expDispData;
            mLastAddr = expAddr;
            mDispDue  = dispWin;
            if (dispWin) mDispDueData = shadow[bus.dispAddr];
            if (cpuWin) begin
                mAckCycle   = cyc + 1;
                mAckRead    = !bus.cpuWrite;
                if (bus.cpuWrite) shadow[bus.cpuAddr] = bus.cpuDataIn;
                else              mAckData = shadow[bus.cpuAddr];
                mPending    = 0;
                mRefused    = 0;
                mAcceptFrom = cyc + 3;
            end else if (mPending && cyc >= mEligible && bus.dispReq) begin
                if (mRefused < MAX_WAIT) mRefused++;
            end else if (!mPending && cyc >= mAcceptFrom && bus.cpuReq) begin
                mPending  = 1;
                mEligible = cyc + 1;
                mRefused  = 0;
            end
        end
        cyc++;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        modelCompare();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setCpu(input logic req, input logic wr, input logic [15:0] a, input logic [7:0] d);
        bus.cpuReq    = req;
        bus.cpuWrite  = wr;
        bus.cpuAddr   = a;
        bus.cpuDataIn = d;
    endtask

    task automatic idle(input int n);
        bus.dispReq = 1'b0;
        bus.cpuReq  = 1'b0;
        for (int i = 0; i < n; i++) begin
            sampleCycle();
            nextCycle();
        end
    endtask

    // One CPU transaction from C_IDLE; lat is the cycle of cpuAck counted from the raise (-1 on timeout).
    task automatic cpuXfer(input logic wr, input logic [15:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd, output int weCnt);
        lat   = -1;
        rd    = '0;
        weCnt = 0;
        setCpu(1'b1, wr, a, d);
        for (int k = 0; k < 4 * MAX_WAIT; k++) begin
            sampleCycle();
            weCnt += int'(bus.ramWriteEnabled);
            if (bus.cpuAck) begin
                lat = k;
                rd  = bus.cpuDataOut;
            end
            nextCycle();
            if (lat >= 0) break;
        end
        bus.cpuReq = 1'b0;
        sampleCycle();
        weCnt += int'(bus.ramWriteEnabled);
        nextCycle();
    endtask

    function automatic logic [15:0] randAddr();
        return ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
    endfunction

    logic [7:0] dispVals [4] = '{8'h5A, 8'hC3, 8'h0F, 8'h96};
    int         rates    [4] = '{0, 30, 70, 100};

    initial begin
        int         lat;
        int         weCnt;
        int         grantCyc;
        int         ackCyc;
        int         misses;
        logic [7:0] rd;
        bit         ackSeen;

        reset        = 1'b1;
        bus.dispReq  = 1'b0;
        bus.dispAddr = '0;
        setCpu(1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sampleCycle();
            nextCycle();
        end
        reset = 1'b0;

        sampleCycle();
        check("reset dispValid", bus.dispValid, 0);
        check("reset cpuAck", bus.cpuAck, 0);
        check("reset ramAddress", bus.ramAddress, 0);
        check("reset dispData", bus.dispData, 0);
        nextCycle();
        idle(1);

        // CPU read with idle display: write 0xA5 to 0x1234, then read it back.
        cpuXfer(1'b1, 16'h1234, 8'hA5, lat, rd, weCnt);
        check("write latency", lat, 2);
        check("write strobe count", weCnt, 1);
        setCpu(1'b1, 1'b0, 16'h1234, 8'h00);
        sampleCycle();
        check("read c0 ack", bus.cpuAck, 0);
        nextCycle();
        sampleCycle();
        check("read c1 addr", bus.ramAddress, 16'h1234);
        check("read c1 we", bus.ramWriteEnabled, 0);
        check("read c1 ack", bus.cpuAck, 0);
        nextCycle();
        sampleCycle();
        check("read c2 ack", bus.cpuAck, 1);
        check("read c2 data", bus.cpuDataOut, 8'hA5);
        nextCycle();
        bus.cpuReq = 1'b0;
        sampleCycle();
        check("read c3 ack single", bus.cpuAck, 0);
        check("read c3 data held", bus.cpuDataOut, 8'hA5);
        nextCycle();

        // Write then read at 0x0010.
        cpuXfer(1'b1, 16'h0010, 8'h3C, lat, rd, weCnt);
        check("wr010 strobe count", weCnt, 1);
        cpuXfer(1'b0, 16'h0010, 8'h00, lat, rd, weCnt);
        check("rd010 latency", lat, 2);
        check("rd010 data", rd, 8'h3C);
        check("rd010 strobe count", weCnt, 0);

        // Display stream over addresses 0..3.
        for (int i = 0; i < 4; i++) begin
            cpuXfer(1'b1, 16'(i), dispVals[i], lat, rd, weCnt);
        end
        for (int k = 0; k < 6; k++) begin
            bus.dispReq  = (k < 4);
            bus.dispAddr = 16'(k);
            sampleCycle();
            check("stream miss", bus.dispMiss, 0);
            check("stream valid", bus.dispValid, (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) check("stream data", bus.dispData, dispVals[k-1]);
            if (k == 5) check("stream data held", bus.dispData, dispVals[3]);
            nextCycle();
        end

        // Starvation: display held high, CPU read of 0x0010 raised.
        bus.dispReq  = 1'b1;
        bus.dispAddr = 16'h0020;
        setCpu(1'b1, 1'b0, 16'h0010, 8'h00);
        grantCyc = -1;
        ackCyc   = -1;
        misses   = 0;
        rd       = '0;
        for (int k = 0; k < 4 * MAX_WAIT; k++) begin
            sampleCycle();
            if (bus.dispMiss) begin
                misses++;
                if (grantCyc < 0) grantCyc = k;
                check("starve grant addr", bus.ramAddress, 16'h0010);
            end
            if (bus.cpuAck) begin
                ackCyc = k;
                rd     = bus.cpuDataOut;
            end
            nextCycle();
            if (ackCyc >= 0) break;
        end
        check("starve grant cycle", grantCyc, MAX_WAIT + 1);
        check("starve ack cycle", ackCyc, MAX_WAIT + 2);
        check("starve latency bound", (ackCyc >= 0 && ackCyc <= MAX_WAIT + 3), 1);
        check("starve miss count", misses, 1);
        check("starve read data", rd, 8'h3C);
        idle(2);

        // Same-cycle conflict: display wins, CPU granted when dispReq first drops (cycle 3).
        setCpu(1'b1, 1'b0, 16'h0010, 8'h00);
        ackCyc = -1;
        misses = 0;
        for (int k = 0; k < 4 * MAX_WAIT; k++) begin
            bus.dispReq  = (k < 3);
            bus.dispAddr = 16'h0005;
            sampleCycle();
            if (k == 0) check("conflict disp addr", bus.ramAddress, 16'h0005);
            misses += int'(bus.dispMiss);
            if (bus.cpuAck) ackCyc = k;
            nextCycle();
            if (ackCyc >= 0) break;
        end
        check("conflict ack cycle", ackCyc, 4);
        check("conflict misses", misses, 0);
        idle(2);

        // Reset in the CPU grant cycle, with a display read in flight.
        setCpu(1'b1, 1'b1, 16'h0040, 8'h77);
        bus.dispReq  = 1'b1;
        bus.dispAddr = 16'h0002;
        sampleCycle();
        check("rst disp grant addr", bus.ramAddress, 16'h0002);
        nextCycle();
        bus.dispReq = 1'b0;
        reset       = 1'b1;
        sampleCycle();
        nextCycle();
        reset      = 1'b0;
        bus.cpuReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sampleCycle();
            check("post-rst cpuAck", bus.cpuAck, 0);
            check("post-rst dispValid", bus.dispValid, 0);
            check("post-rst ramWE", bus.ramWriteEnabled, 0);
            check("post-rst ramAddress", bus.ramAddress, 0);
            check("post-rst dispData", bus.dispData, 0);
            check("post-rst cpuDataOut", bus.cpuDataOut, 0);
            nextCycle();
        end
        cpuXfer(1'b0, 16'h0040, 8'h00, lat, rd, weCnt);
        check("discarded write", rd, 8'h00);

        // Randomized traffic in phases of increasing display load.
        ackSeen = 0;
        for (int k = 0; k < 2000; k++) begin
            reset = (k > 20 && $urandom_range(0, 199) == 0);
            if (reset || (bus.cpuReq && ackSeen)) begin
                bus.cpuReq = 1'b0;
            end else if (!bus.cpuReq && $urandom_range(0, 3) == 0) begin
                setCpu(1'b1, 1'($urandom_range(0, 1)), randAddr(), 8'($urandom));
            end
            bus.dispReq  = ($urandom_range(0, 99) < rates[(k / 250) % 4]);
            bus.dispAddr = randAddr();
            sampleCycle();
            ackSeen = bus.cpuAck;
            nextCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
